pong_collision_engine: RTL and testbench

Clocked, parametrised collision and scoring engine for the Pong datapath. Once per frame it compares the ball position from ball movement with both paddle positions from paddle movement. It emits one-cycle hit and point pulses, keeps both players' scores, and detects the end of the game. It replaces the earlier combinational collision check and adds registered outputs, configurable geometry, point de-bounce and win detection.

---
 rtl/pong_collision_engine.sv | 202 ++++++++++++++++++++
 tb/tb_pong_collision_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_collision_engine.sv
// pong_collision_engine
// Frame-rate collision and scoring engine for the Pong datapath.
// On every frame strobe it compares the ball position against both paddles and
// the wall rows. It emits one-cycle hit/point pulses, keeps both scores and
// detects the end of the game.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                frame strobe; bx/by/p1y/p2y sampled only when high
//   clr_scores          synchronous new-game request (beats tick)
//   bx, by              ball position
//   p1y, p2y            paddle top rows
//   paddle_hit          pulse: ball struck a paddle
//   hit_side            0 = left paddle, 1 = right paddle (valid with paddle_hit)
//   hit_offset          by - paddle top (valid with paddle_hit)
//   wall_hit            pulse: ball on the top or bottom wall row
//   point_p1, point_p2  pulse: that player scored
//   score1, score2      current scores
//   game_over, winner   level in OVER; winner 0 = player 1, 1 = player 2
module pong_collision_engine #(
    parameter int unsigned X_W       = 6,
    parameter int unsigned Y_W       = 6,
    parameter int unsigned FIELD_H   = 64,
    parameter int unsigned PADDLE_H  = 6,
    parameter int unsigned P1_X      = 2,
    parameter int unsigned P2_X      = 61,
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned WIN_SCORE = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        clr_scores,
    input  logic [X_W-1:0]              bx,
    input  logic [Y_W-1:0]              by,
    input  logic [Y_W-1:0]              p1y,
    input  logic [Y_W-1:0]              p2y,
    output logic                        paddle_hit,
    output logic                        hit_side,
    output logic [$clog2(PADDLE_H)-1:0] hit_offset,
    output logic                        wall_hit,
    output logic                        point_p1,
    output logic                        point_p2,
    output logic [SCORE_W-1:0]          score1,
    output logic [SCORE_W-1:0]          score2,
    output logic                        game_over,
    output logic                        winner
);

    localparam int unsigned OFF_W = $clog2(PADDLE_H);
    // One extra bit so a paddle near the bottom row never wraps through 0.
    localparam int unsigned E_W   = Y_W + 1;

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_SCORED = 2'd1,
        S_OVER   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_paddle_hit;
    logic                 r_hit_side;
    logic [OFF_W-1:0]     r_hit_offset;
    logic                 r_wall_hit;
    logic                 r_point_p1;
    logic                 r_point_p2;
    logic [SCORE_W-1:0]   r_score1;
    logic [SCORE_W-1:0]   r_score2;
    logic                 r_game_over;
    logic                 r_winner;

    logic [E_W-1:0]       w_by_e;
    logic [E_W-1:0]       w_p1_lo;
    logic [E_W-1:0]       w_p1_hi;
    logic [E_W-1:0]       w_p2_lo;
    logic [E_W-1:0]       w_p2_hi;
    logic                 w_in1;
    logic                 w_in2;
    logic [OFF_W-1:0]     w_off1;
    logic [OFF_W-1:0]     w_off2;
    logic                 w_at1;
    logic                 w_at2;
    logic                 w_wall;
    logic [SCORE_W-1:0]   w_s1_inc;
    logic [SCORE_W-1:0]   w_s2_inc;
    logic                 w_s1_win;
    logic                 w_s2_win;

    // Paddle range tests on widened coordinates.
    assign w_by_e  = E_W'(by);
    assign w_p1_lo = E_W'(p1y);
    assign w_p2_lo = E_W'(p2y);
    assign w_p1_hi = w_p1_lo + E_W'(PADDLE_H - 1);
    assign w_p2_hi = w_p2_lo + E_W'(PADDLE_H - 1);
    assign w_in1   = (w_by_e >= w_p1_lo) && (w_by_e <= w_p1_hi);
    assign w_in2   = (w_by_e >= w_p2_lo) && (w_by_e <= w_p2_hi);
    assign w_off1  = OFF_W'(by - p1y);
    assign w_off2  = OFF_W'(by - p2y);

    assign w_at1   = (bx == X_W'(P1_X));
    assign w_at2   = (bx == X_W'(P2_X));
    assign w_wall  = (by == Y_W'(0)) || (by == Y_W'(FIELD_H - 1));

    assign w_s1_inc = r_score1 + SCORE_W'(1);
    assign w_s2_inc = r_score2 + SCORE_W'(1);
    assign w_s1_win = (w_s1_inc == SCORE_W'(WIN_SCORE));
    assign w_s2_win = (w_s2_inc == SCORE_W'(WIN_SCORE));

    // Game FSM with registered pulses and scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PLAY;
            r_paddle_hit <= 1'b0;
            r_hit_side   <= 1'b0;
            r_hit_offset <= '0;
            r_wall_hit   <= 1'b0;
            r_point_p1   <= 1'b0;
            r_point_p2   <= 1'b0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_paddle_hit <= 1'b0;
            r_wall_hit   <= 1'b0;
            r_point_p1   <= 1'b0;
            r_point_p2   <= 1'b0;

            if (clr_scores) begin
                r_state     <= S_PLAY;
                r_score1    <= '0;
                r_score2    <= '0;
                r_game_over <= 1'b0;
                r_winner    <= 1'b0;
            end else if (tick) begin
                case (r_state)
                    S_PLAY: begin
                        // Wall check is independent of the column checks.
                        r_wall_hit <= w_wall;
                        if (w_at1) begin
                            if (w_in1) begin
                                r_paddle_hit <= 1'b1;
                                r_hit_side   <= 1'b0;
                                r_hit_offset <= w_off1;
                            end else begin
                                r_point_p2 <= 1'b1;
                                r_score2   <= w_s2_inc;
                                if (w_s2_win) begin
                                    r_state     <= S_OVER;
                                    r_game_over <= 1'b1;
                                    r_winner    <= 1'b1;
                                end else begin
                                    r_state <= S_SCORED;
                                end
                            end
                        end else if (w_at2) begin
                            if (w_in2) begin
                                r_paddle_hit <= 1'b1;
                                r_hit_side   <= 1'b1;
                                r_hit_offset <= w_off2;
                            end else begin
                                r_point_p1 <= 1'b1;
                                r_score1   <= w_s1_inc;
                                if (w_s1_win) begin
                                    r_state     <= S_OVER;
                                    r_game_over <= 1'b1;
                                    r_winner    <= 1'b0;
                                end else begin
                                    r_state <= S_SCORED;
                                end
                            end
                        end
                    end
                    S_SCORED: begin
                        // Wait for the ball to leave both scoring columns; this tick is not evaluated.
                        if (!w_at1 && !w_at2) begin
                            r_state <= S_PLAY;
                        end
                    end
                    S_OVER: begin
                        r_state <= S_OVER;
                    end
                    default: begin
                        r_state <= S_PLAY;
                    end
                endcase
            end
        end
    end

    assign paddle_hit = r_paddle_hit;
    assign hit_side   = r_hit_side;
    assign hit_offset = r_hit_offset;
    assign wall_hit   = r_wall_hit;
    assign point_p1   = r_point_p1;
    assign point_p2   = r_point_p2;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_pong_collision_engine.sv
// Testbench for pong_collision_engine: table of per-tick vectors with expected
// outputs, queued when driven and compared after the sampling edge, plus a
// hand-written asynchronous reset sequence.
module tb_pong_collision_engine;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       clr_scores;
    logic [5:0] bx;
    logic [5:0] by;
    logic [5:0] p1y;
    logic [5:0] p2y;
    logic       paddle_hit;
    logic       hit_side;
    logic [2:0] hit_offset;
    logic       wall_hit;
    logic       point_p1;
    logic       point_p2;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    pong_collision_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .clr_scores (clr_scores),
        .bx         (bx),
        .by         (by),
        .p1y        (p1y),
        .p2y        (p2y),
        .paddle_hit (paddle_hit),
        .hit_side   (hit_side),
        .hit_offset (hit_offset),
        .wall_hit   (wall_hit),
        .point_p1   (point_p1),
        .point_p2   (point_p2),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       tick;
        logic       clr;
        logic [5:0] bx;
        logic [5:0] by;
        logic [5:0] p1y;
        logic [5:0] p2y;
        logic       ph;
        logic       side;
        logic [2:0] off;
        logic       wall;
        logic       pp1;
        logic       pp2;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       go;
        logic       win;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    task automatic add(input logic t, input logic c, input int xb, input int yb,
                       input int y1, input int y2, input logic ph, input logic sd,
                       input int off, input logic wl, input logic a1, input logic a2,
                       input int s1, input int s2, input logic go, input logic wn);
        vec_t v;
        v.id   = tbl.size();
        v.tick = t;
        v.clr  = c;
        v.bx   = 6'(xb);
        v.by   = 6'(yb);
        v.p1y  = 6'(y1);
        v.p2y  = 6'(y2);
        v.ph   = ph;
        v.side = sd;
        v.off  = 3'(off);
        v.wall = wl;
        v.pp1  = a1;
        v.pp2  = a2;
        v.s1   = 4'(s1);
        v.s2   = 4'(s2);
        v.go   = go;
        v.win  = wn;
        tbl.push_back(v);
    endtask

    // Output monitor: compares one queued expectation per clock after the edge.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("paddle_hit", e.id, int'(paddle_hit), int'(e.ph));
            if (e.ph) begin
                chk("hit_side", e.id, int'(hit_side), int'(e.side));
                chk("hit_offset", e.id, int'(hit_offset), int'(e.off));
            end
            chk("wall_hit", e.id, int'(wall_hit), int'(e.wall));
            chk("point_p1", e.id, int'(point_p1), int'(e.pp1));
            chk("point_p2", e.id, int'(point_p2), int'(e.pp2));
            chk("score1", e.id, int'(score1), int'(e.s1));
            chk("score2", e.id, int'(score2), int'(e.s2));
            chk("game_over", e.id, int'(game_over), int'(e.go));
            chk("winner", e.id, int'(winner), int'(e.win));
        end
    end

    task automatic chk_reset_vals(input int id);
        chk("rst paddle_hit", id, int'(paddle_hit), 0);
        chk("rst hit_side", id, int'(hit_side), 0);
        chk("rst hit_offset", id, int'(hit_offset), 0);
        chk("rst wall_hit", id, int'(wall_hit), 0);
        chk("rst point_p1", id, int'(point_p1), 0);
        chk("rst point_p2", id, int'(point_p2), 0);
        chk("rst score1", id, int'(score1), 0);
        chk("rst score2", id, int'(score2), 0);
        chk("rst game_over", id, int'(game_over), 0);
        chk("rst winner", id, int'(winner), 0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        tick       = 1'b0;
        clr_scores = 1'b0;
        bx         = '0;
        by         = '0;
        p1y        = '0;
        p2y        = '0;

        //  tick clr bx  by  p1y p2y | ph sd off wl p1 p2 s1 s2 go win
        add(1, 0,  2, 12, 10, 20,   1, 0, 2,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 30, 12, 10, 20,   0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 61, 40, 10, 20,   0, 0, 0,  0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(1, 0, 61, 40, 10, 20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 30, 30, 10, 20,   0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 61, 22, 10, 20,   1, 1, 2,  0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 30,  0, 10, 20,   0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 30, 63, 10, 20,   0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        add(1, 0,  2,  0, 60, 20,   0, 0, 0,  1, 0, 1, 1, 1, 0, 0);
        add(1, 0, 30,  5, 60, 20,   0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
        add(1, 0,  2, 63, 58, 20,   1, 0, 5,  1, 0, 0, 1, 1, 0, 0);
        add(1, 0,  2, 15, 10, 20,   1, 0, 5,  0, 0, 0, 1, 1, 0, 0);
        add(1, 0,  2, 16, 10, 20,   0, 0, 0,  0, 0, 1, 1, 2, 0, 0);
        add(0, 0, 30,  5, 10, 20,   0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
        add(1, 0,  2, 16, 10, 20,   0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
        add(1, 0, 30,  0, 10, 20,   0, 0, 0,  0, 0, 0, 1, 2, 0, 0);
        for (int k = 3; k <= 10; k++) begin
            add(1, 0,  2, 16, 10, 20, 0, 0, 0, 0, 0, 1, 1, k, 0, 0);
            add(1, 0, 30,  0, 10, 20, 0, 0, 0, 0, 0, 0, 1, k, 0, 0);
        end
        add(1, 0,  2, 16, 10, 20,   0, 0, 0,  0, 0, 1, 1, 11, 1, 1);
        add(1, 0,  2, 16, 10, 20,   0, 0, 0,  0, 0, 0, 1, 11, 1, 1);
        add(1, 0, 61,  0, 10, 20,   0, 0, 0,  0, 0, 0, 1, 11, 1, 1);
        add(1, 0, 30, 63, 10, 20,   0, 0, 0,  0, 0, 0, 1, 11, 1, 1);
        add(1, 1,  2, 12, 10, 20,   0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add(1, 0,  2, 12, 10, 20,   1, 0, 2,  0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            add(1, 0, 61, 40, 10, 20, 0, 0, 0, 0, 1, 0, k, 0, 0, 0);
            add(1, 0, 30,  5, 10, 20, 0, 0, 0, 0, 0, 0, k, 0, 0, 0);
        end
        add(1, 0, 61, 40, 10, 20,   0, 0, 0,  0, 1, 0, 11, 0, 1, 0);
        add(1, 0, 61, 40, 10, 20,   0, 0, 0,  0, 0, 0, 11, 0, 1, 0);
        add(0, 1, 30,  5, 10, 20,   0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals(-1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            tick       = tbl[i].tick;
            clr_scores = tbl[i].clr;
            bx         = tbl[i].bx;
            by         = tbl[i].by;
            p1y        = tbl[i].p1y;
            p2y        = tbl[i].p2y;
            exp_q.push_back(tbl[i]);
        end
        @(negedge clk);
        tick       = 1'b0;
        clr_scores = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        // Asynchronous reset in the middle of a paddle_hit pulse.
        @(negedge clk);
        tick = 1'b1;
        bx   = 6'd2;
        by   = 6'd12;
        p1y  = 6'd10;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk("pre-reset paddle_hit", -2, int'(paddle_hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(-2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
